// File: rtl/bcd_subtractor_2_digits_seq.sv
// Sequential two-digit BCD subtractor.
// Computes a_bcd - b_bcd - borrow_in one digit per clock through a single
// shared digit subtract unit and reports a sign-magnitude BCD result.
// Negative raw results are turned into a magnitude by a ten's complement
// (0 - raw) that reuses the same digit unit for two more cycles.
// The encoding diff_bcd=8'h00 with negative=1 stands for -100.
module bcd_subtractor_2_digits_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a_bcd,
    input  logic [7:0] b_bcd,
    input  logic       borrow_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] diff_bcd,
    output logic       negative,
    output logic       error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SUB0,
        ST_SUB1,
        ST_COMP0,
        ST_COMP1,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Operands captured on the accepted start edge
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic       bin_r;

    // Intermediate digits and the borrow chained between digit steps
    logic [3:0] raw0;
    logic [3:0] raw1;
    logic       borrow_r;

    // Shared digit subtract unit ports
    logic [3:0] du_x;
    logic [3:0] du_y;
    logic       du_bin;
    logic [4:0] du_diff;
    logic [3:0] du_digit;
    logic       du_bout;

    // Operand validity
    logic       operand_bad;

    // ------------------------------------------------------------------
    // Operand check: any latched digit above 9 makes the request invalid
    // ------------------------------------------------------------------
    always_comb begin
        operand_bad = (a_r[3:0] > 4'd9) || (a_r[7:4] > 4'd9) ||
                      (b_r[3:0] > 4'd9) || (b_r[7:4] > 4'd9);
    end

    // ------------------------------------------------------------------
    // Digit unit input selection, driven by the current step
    // ------------------------------------------------------------------
    always_comb begin
        du_x   = '0;
        du_y   = '0;
        du_bin = 1'b0;
        case (state)
            ST_SUB0: begin
                du_x   = a_r[3:0];
                du_y   = b_r[3:0];
                du_bin = bin_r;
            end
            ST_SUB1: begin
                du_x   = a_r[7:4];
                du_y   = b_r[7:4];
                du_bin = borrow_r;
            end
            ST_COMP0: begin
                du_x   = 4'd0;
                du_y   = raw0;
                du_bin = 1'b0;
            end
            ST_COMP1: begin
                du_x   = 4'd0;
                du_y   = raw1;
                du_bin = borrow_r;
            end
            default: begin
                du_x   = '0;
                du_y   = '0;
                du_bin = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit unit: x - y - bin in 5-bit two's complement; the range
    // -16..15 always fits, so bit 4 is the sign and hence the borrow out
    // ------------------------------------------------------------------
    always_comb begin
        du_diff  = {1'b0, du_x} - {1'b0, du_y} - {4'b0000, du_bin};
        du_bout  = du_diff[4];
        du_digit = du_bout ? (du_diff[3:0] + 4'd10) : du_diff[3:0];
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = operand_bad ? ST_DONE : ST_SUB0;
            end
            ST_SUB0: begin
                state_next = ST_SUB1;
            end
            ST_SUB1: begin
                state_next = du_bout ? ST_COMP0 : ST_DONE;
            end
            ST_COMP0: begin
                state_next = ST_COMP1;
            end
            ST_COMP1: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake outputs decoded from the state
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Operand capture: only on a start accepted in IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            bin_r <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            a_r   <= a_bcd;
            b_r   <= b_bcd;
            bin_r <= borrow_in;
        end
    end

    // ------------------------------------------------------------------
    // Digit registers: COMP0/COMP1 overwrite raw0/raw1 in place with the
    // complemented digits, since each raw digit is read exactly once
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw0     <= '0;
            raw1     <= '0;
            borrow_r <= 1'b0;
        end else begin
            case (state)
                ST_SUB0: begin
                    raw0     <= du_digit;
                    borrow_r <= du_bout;
                end
                ST_SUB1: begin
                    raw1     <= du_digit;
                    borrow_r <= du_bout;
                end
                ST_COMP0: begin
                    raw0     <= du_digit;
                    borrow_r <= du_bout;
                end
                ST_COMP1: begin
                    // borrow out of the top complement digit is discarded
                    raw1 <= du_digit;
                end
                default: begin
                    raw0     <= raw0;
                    raw1     <= raw1;
                    borrow_r <= borrow_r;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result registers: written only on the edge that enters DONE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_bcd <= '0;
            negative <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                ST_CHECK: begin
                    if (operand_bad) begin
                        diff_bcd <= '0;
                        negative <= 1'b0;
                        error    <= 1'b1;
                    end
                end
                ST_SUB1: begin
                    if (!du_bout) begin
                        diff_bcd <= {du_digit, raw0};
                        negative <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                ST_COMP1: begin
                    diff_bcd <= {du_digit, raw0};
                    negative <= 1'b1;
                    error    <= 1'b0;
                end
                default: begin
                    diff_bcd <= diff_bcd;
                    negative <= negative;
                    error    <= error;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_subtractor_2_digits_seq.md
# bcd_subtractor_2_digits_seq

Sequential two-digit BCD subtractor, the inverse-operation companion to the two-digit BCD adder on the switch/LED/7-segment board designs. It takes two 2-digit BCD operands and a borrow-in, and subtracts them one digit per clock through a single shared digit subtract unit. It returns a sign-magnitude BCD difference with a start/busy/done handshake. Output digits feed the existing hex decoders, and flags drive LEDs.

## Interface
- Parameters: none.
- `clk` — input, 1 bit. System clock; all state changes on the rising edge.
- `rst_n` — input, 1 bit. One clock domain; reset is asynchronous and active-low.
- `start` — input, 1 bit. Request, sampled on a rising edge, honoured only in IDLE.
- `a_bcd` — input, 8 bits. Minuend: [3:0] ones digit, [7:4] tens digit.
- `b_bcd` — input, 8 bits. Subtrahend, same layout.
- `borrow_in` — input, 1 bit. Subtracted from the ones digit.
- `busy` — output, 1 bit. High in every state except IDLE.
- `done` — output, 1 bit. One-cycle pulse, high while in DONE.
- `diff_bcd` — output, 8 bits. Magnitude of the result, BCD.
- `negative` — output, 1 bit. 1 when a − b − borrow_in < 0.
- `error` — output, 1 bit. 1 when any operand digit is > 9.

## Operation
- **States:** IDLE, CHECK, SUB0, SUB1, COMP0, COMP1, DONE. Exactly one transition per clock.
- **IDLE:**
  - With start=1: latch a_bcd, b_bcd and borrow_in into internal registers, then go to CHECK.
  - With start=0: stay in IDLE.
- **CHECK:**
  - If any latched digit is > 9: go to DONE with error=1, diff_bcd=8'h00, negative=0.
  - Otherwise: go to SUB0.
- **Digit subtract unit:** d = x − y − bin, computed in 5-bit signed arithmetic.
  - If d < 0: digit = d + 10 and bout = 1.
  - Otherwise: digit = d and bout = 0.
- **SUB0:** ones digit, using the latched borrow_in. Register raw0 and the borrow, then go to SUB1.
- **SUB1:** tens digit, using the borrow from SUB0. Register raw1 and the final borrow.
  - Final borrow = 0: go to DONE with diff_bcd = {raw1, raw0} and negative=0.
  - Final borrow = 1: go to COMP0.
- **COMP0/COMP1:** ten's complement of the raw result.
  - Computed as 0 − raw using the same digit unit: COMP0 with bin=0, COMP1 with the borrow from COMP0.
  - After COMP1: go to DONE with diff_bcd = complemented digits and negative=1.
  - The borrow out of COMP1 is discarded.
- **Boundary case:** the −100 result (a=00, b=99, borrow_in=1) gives raw 00 with a borrow. It is reported as diff_bcd=8'h00 with negative=1, and this encoding is defined to mean −100.
- **DONE:** assert done, then go to IDLE on the next edge.
- **Result holding:** diff_bcd, negative and error are written only on the edge that enters DONE. They hold until the next operation reaches DONE.
- **Inputs:** changes to a_bcd, b_bcd or borrow_in after the start edge have no effect on the operation in progress.
- **start while busy:** ignored in every non-IDLE state, including DONE. It is not queued.

## Timing
- **Reset:** rst_n low forces IDLE asynchronously. busy, done, diff_bcd, negative and error all reset to 0, and internal operand and borrow registers clear. This applies mid-operation, and the aborted operation never produces done.
- **Reset release:** the first start is accepted on the first rising edge with rst_n high.
- **Latency:** edge E0 samples start. done is high during the cycle following:
  - E3 for a non-negative result;
  - E5 for a negative result;
  - E1 for an invalid operand.
- **busy:** rises after E0 and falls after the edge that leaves DONE.
- **Back-to-back throughput:** a new start is accepted on the edge leaving DONE + 1 at the earliest. The minimum period is 5 cycles for non-negative results and 7 for negative ones.

## Test plan
- **Plain difference:** a=8'h45, b=8'h23, borrow_in=0, start pulse → done 4 cycles after the start edge; diff_bcd=8'h22, negative=0, error=0; busy high for 4 cycles.
- **Inner and outer borrow:** a=8'h23, b=8'h45, borrow_in=0 → raw 78 with borrow, then complement; after 6 cycles diff_bcd=8'h22, negative=1.
- **Borrow-in and −100 case:**
  - a=8'h00, b=8'h00, borrow_in=1 → diff_bcd=8'h01, negative=1.
  - a=8'h00, b=8'h99, borrow_in=1 → diff_bcd=8'h00, negative=1.
- **Invalid operand:** a=8'h3A, b=8'h12 → done 2 cycles after start; error=1, diff_bcd=8'h00, negative=0. Then a valid 8'h12 − 8'h12 → diff_bcd=8'h00, error=0.
- **start while busy and held results:** start asserted in every cycle during an operation and during DONE → only one done pulse per accepted start. Operand inputs changed mid-operation do not alter the result.
- **Reset mid-operation:** drop rst_n during COMP0 → all outputs 0 immediately and no done pulse. After release, a fresh 8'h50 − 8'h07 → diff_bcd=8'h43.
